// File: rtl/subservient_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subservient_loader_pkg
// Description : Shared types and constants for the subservient firmware
//               loader: FSM state encoding, Wishbone byte-select constant
//               and the byte-lane index width.
// Revision    : 1.0 - initial release
// ============================================================================
package subservient_loader_pkg;

  // Two bits select one of the four byte lanes of a 32-bit word
  localparam int LANE_W = 2;

  // Every loader access is a full-word access
  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  // READ is only reachable when readback is compiled in
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/subservient_loader_pack.sv
`default_nettype none
// ============================================================================
// Module      : subservient_loader_pack
// Description : Byte-to-word packer. Places successive accepted bytes into
//               lanes 0..3 (little-endian) and flags the byte that completes
//               a word. i_clear restarts at lane 0 with an empty word.
// Revision    : 1.0 - initial release
// ============================================================================
module subservient_loader_pack
  import subservient_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       word_q, word_d;

  // Next lane index and word contents
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (i_clear) begin
      lane_d = '0;
      word_d = '0;
    end else if (i_byte_en) begin
      word_d[{lane_q, 3'b000} +: 8] = i_byte;
      lane_d                        = lane_q + 1'b1;
    end
  end

  // Lane counter and word register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  // High on the byte that fills lane 3; the full word is in o_word next cycle
  assign o_word_valid = i_byte_en & ~i_clear & (lane_q == 2'd3);
  assign o_word       = word_q;

endmodule
`default_nettype wire

// File: rtl/subservient_wb_loader.sv
`default_nettype none
// ============================================================================
// Module      : subservient_wb_loader
// Description : Wishbone initiator that packs a byte stream into 32-bit words
//               and writes them to consecutive SRAM word addresses starting
//               at a programmable base. Optional readback-and-compare is
//               enabled by defining SUBSERVIENT_LOADER_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module subservient_wb_loader
  import subservient_loader_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [aw-3:0] i_base,
  input  logic [aw-3:0] i_len,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int            WW       = aw - 2;
  localparam logic [WW-1:0] WORD_ONE = {{(WW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [WW-1:0]   adr_q, adr_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pack_clear;
  logic            byte_fire;
  logic            word_valid;
  logic [31:0]     word;
  logic            advance;
  logic            read_stb;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
  logic            err_q, err_d;
`endif

  assign byte_fire = i_valid & ready_q;

  subservient_loader_pack u_pack (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (pack_clear),
    .i_byte_en    (byte_fire),
    .i_byte       (i_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  // Next-state logic; outputs are derived from the next state so they register
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    pack_clear = 1'b0;
    advance    = 1'b0;
    read_stb   = 1'b0;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          adr_d      = i_base;
          cnt_d      = i_len;
          pack_clear = 1'b1;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
          err_d      = 1'b0;
`endif
          state_d    = (i_len == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (i_wb_ack) begin
`ifdef SUBSERVIENT_LOADER_READBACK_EN
          // Strobe stays low for one cycle before the read is issued
          state_d = ST_READ;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef SUBSERVIENT_LOADER_READBACK_EN
      ST_READ: begin
        if (!stb_q) begin
          read_stb = 1'b1;
        end else if (i_wb_ack) begin
          if (i_wb_rdt != word) err_d = 1'b1;
          advance = 1'b1;
        end else begin
          read_stb = 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      adr_d   = adr_q + WORD_ONE;
      cnt_d   = cnt_q - WORD_ONE;
      state_d = (cnt_q == WORD_ONE) ? ST_DONE : ST_FILL;
    end

    ready_d = (state_d == ST_FILL);
    stb_d   = (state_d == ST_WRITE) | read_stb;
    we_d    = (state_d == ST_WRITE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, address, count and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SUBSERVIENT_LOADER_READBACK_EN
  // Sticky readback mismatch flag, cleared only by an accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign o_err = err_q;
`else
  logic unused_rdt;
  assign unused_rdt = ^i_wb_rdt;
  assign o_err      = 1'b0;
`endif

  assign o_ready  = ready_q;
  assign o_wb_adr = adr_q;
  assign o_wb_dat = word;
  assign o_wb_sel = WB_SEL_ALL;
  assign o_wb_we  = we_q;
  assign o_wb_stb = stb_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_subservient_wb_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_subservient_wb_loader
// Description : Self-checking bench for subservient_wb_loader with a
//               behavioural SRAM responder and an expected-write queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subservient_wb_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int NW    = 64;
`ifdef SUBSERVIENT_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        i_clk, i_rst_n, i_start, i_valid, i_wb_ack;
  logic [5:0]  i_base, i_len, o_wb_adr;
  logic [7:0]  i_data;
  logic [31:0] o_wb_dat, i_wb_rdt;
  logic [3:0]  o_wb_sel;
  logic        o_ready, o_wb_we, o_wb_stb, o_busy, o_done, o_err;

  subservient_wb_loader #(.depth(DEPTH), .aw(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base(i_base),
    .i_len(i_len), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt),
    .i_wb_ack(i_wb_ack), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: expected writes, SRAM contents, event counters
  logic [5:0]  exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [7:0]  stream[$];
  logic [31:0] mem[NW];
  int          ack_delay   = 4;
  bit          corrupt     = 1'b0;
  int          stb_cycles  = 0;
  int          done_pulses = 0;
  int          cnt         = 0;
  logic [5:0]  hold_adr;
  logic [31:0] hold_dat;
  logic        hold_we;
  bit          hold_ok;

  // SRAM responder: acks after ack_delay strobe cycles, checks held request
  always @(negedge i_clk) begin
    if (o_done === 1'b1) done_pulses++;
    if (i_wb_ack) begin
      check("stb_drop_after_ack", {31'd0, o_wb_stb}, 32'd0);
      i_wb_ack = 1'b0;
      cnt      = 0;
    end else if (o_wb_stb) begin
      stb_cycles++;
      if (cnt == 0) begin
        hold_adr = o_wb_adr; hold_dat = o_wb_dat; hold_we = o_wb_we; hold_ok = 1'b1;
      end else if (o_wb_adr !== hold_adr || o_wb_dat !== hold_dat || o_wb_we !== hold_we) begin
        hold_ok = 1'b0;
      end
      cnt++;
      if (cnt >= ack_delay) begin
        i_wb_ack = 1'b1;
        check("req_held", {31'd0, hold_ok}, 32'd1);
        check("sel", {28'd0, o_wb_sel}, 32'hF);
        if (o_wb_we) begin
          mem[o_wb_adr] = o_wb_dat;
          if (exp_adr.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            check("wr_adr", {26'd0, o_wb_adr}, {26'd0, exp_adr.pop_front()});
            check("wr_dat", o_wb_dat, exp_dat.pop_front());
          end
        end else begin
          i_wb_rdt = corrupt ? 32'hDEADBEEF : mem[o_wb_adr];
          corrupt  = 1'b0;
        end
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic start_load(input logic [5:0] base, input logic [5:0] len);
    i_base  = base;
    i_len   = len;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    repeat (stall) @(negedge i_clk);
    t = 0;
    while (!o_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      i_valid = 1'b1;
      i_data  = b;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_data  = 8'($urandom);
    end
  endtask

  // One complete load; uses bytes from `stream` if supplied, else random ones
  task automatic run_load(input int base, input int len, input int stall, input bit exp_err);
    int          d0, s0, t;
    logic [7:0]  b[$];
    if (stream.size() == 4 * len) b = stream;
    else for (int i = 0; i < 4 * len; i++) b.push_back(8'($urandom));
    stream.delete();
    for (int w = 0; w < len; w++) begin
      exp_adr.push_back(6'((base + w) % NW));
      exp_dat.push_back({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    end
    d0 = done_pulses;
    s0 = stb_cycles;
    start_load(6'(base), 6'(len));
    check("err_after_start", {31'd0, o_err}, 32'd0);
    if (len == 0) begin
      check("zl_done", {31'd0, o_done}, 32'd1);
      check("zl_busy", {31'd0, o_busy}, 32'd1);
      @(negedge i_clk);
      check("zl_done_low", {31'd0, o_done}, 32'd0);
      check("zl_busy_low", {31'd0, o_busy}, 32'd0);
      check("zl_no_stb", 32'(stb_cycles - s0), 32'd0);
    end else begin
      check("ready_rise", {31'd0, o_ready}, 32'd1);
      for (int i = 0; i < 4 * len; i++) send_byte(b[i], stall);
      t = 0;
      while (!o_done && t < 300) begin
        @(negedge i_clk);
        t++;
      end
      check("done_seen", {31'd0, o_done}, 32'd1);
      check("busy_at_done", {31'd0, o_busy}, 32'd1);
      check("err_at_done", {31'd0, o_err}, {31'd0, exp_err});
      @(negedge i_clk);
      check("busy_after", {31'd0, o_busy}, 32'd0);
    end
    repeat (2) @(negedge i_clk);
    check("done_count", 32'(done_pulses - d0), 32'd1);
    check("writes_left", 32'(exp_adr.size()), 32'd0);
    exp_adr.delete();
    exp_dat.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
    i_base = '0; i_len = '0; i_wb_ack = 1'b0; i_wb_rdt = '0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_stb",   {31'd0, o_wb_stb}, 32'd0);
    check("rst_we",    {31'd0, o_wb_we}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_done",  {31'd0, o_done}, 32'd0);
    check("rst_err",   {31'd0, o_err}, 32'd0);
    check("rst_adr",   {26'd0, o_wb_adr}, 32'd0);
    check("rst_dat",   o_wb_dat, 32'd0);
    check("rst_sel",   {28'd0, o_wb_sel}, 32'hF);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed two-word load
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(6'h10, 2, 0, 1'b0);
    // Zero-length load
    run_load(6'h05, 0, 0, 1'b0);
    // Address wrap past the top word
    run_load(NW - 1, 2, 0, 1'b0);
    // Stalled stream and slow acknowledge
    ack_delay = 7;
    run_load(6'h2A, 2, 10, 1'b0);
    ack_delay = 4;

    // Random loads
    for (int k = 0; k < 6; k++) begin
      ack_delay = int'($urandom_range(1, 6));
      run_load(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 2)), 1'b0);
    end
    ack_delay = 4;

    // Corrupted readback; error only reported when readback is built in
    corrupt = 1'b1;
    stream  = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(6'h20, 1, 0, RB);
    check("err_sticky", {31'd0, o_err}, {31'd0, RB});
    corrupt = 1'b0;
    run_load(6'h21, 1, 0, 1'b0);

    // Reset while the write is outstanding
    ack_delay = 7;
    stream    = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    exp_adr.push_back(6'h05);
    exp_dat.push_back(32'hC4C3C2C1);
    start_load(6'h05, 6'd1);
    for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
    stream.delete();
    t = 0;
    while (!o_wb_stb && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check("stb_before_rst", {31'd0, o_wb_stb}, 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_stb",   {31'd0, o_wb_stb}, 32'd0);
    check("rst_mid_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_mid_ready", {31'd0, o_ready}, 32'd0);
    check("rst_mid_dat",   o_wb_dat, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_adr.delete();
    exp_dat.delete();
    @(negedge i_clk);
    ack_delay = 4;
    stream = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_load(6'h05, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/subservient_wb_loader.md
# subservient_wb_loader

Wishbone initiator that streams a firmware image into the subservient shared RF/instruction/data SRAM. It accepts a byte stream (valid/ready) from a debug or UART front end and packs it little-endian into 32-bit words. It issues one full-word Wishbone write per word to the SRAM's Wishbone responder port, starting at a programmable word address. It sits beside the core on the same Wishbone port and is only active while the core is held off the bus.

## Interface
Parameters:
- depth, 256, SRAM depth in bytes; must match the SRAM responder.
- aw, $clog2(depth), byte address width.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_start  input  1  one-cycle request to begin a load; ignored unless idle.
- i_base  input  aw-2  first word address, latched on accepted start.
- i_len  input  aw-2  number of words to load, latched on accepted start; 0 completes immediately.
- i_data  input  8  stream byte.
- i_valid  input  1  stream byte valid.
- o_ready  output  1  loader can accept a byte.
- o_wb_adr  output  aw-2  word address.
- o_wb_dat  output  32  write data.
- o_wb_sel  output  4  byte lanes; always 4'hF.
- o_wb_we  output  1  write enable.
- o_wb_stb  output  1  strobe/cycle.
- i_wb_rdt  input  32  read data; used only for readback.
- i_wb_ack  input  1  one-cycle acknowledge.
- o_busy  output  1  load in progress.
- o_done  output  1  one-cycle pulse when the load finishes.
- o_err  output  1  sticky readback mismatch flag.

## Operation
- States: IDLE, FILL, WRITE, READ, DONE. READ exists only with readback.
- IDLE: an accepted i_start latches base and count, then goes to FILL. If count is 0, it goes to DONE instead.
- FILL:
  - o_ready=1.
  - Each byte with i_valid&o_ready goes to lane k, k=0..3: bits [8k+7:8k].
  - After the fourth byte, go to WRITE.
- WRITE:
  - o_wb_stb=1, o_wb_we=1, o_wb_sel=4'hF.
  - o_wb_adr and o_wb_dat are held stable until i_wb_ack.
  - On ack, go to READ if readback is enabled. Otherwise advance.
- READ: o_wb_stb=1, o_wb_we=0, same address, held until ack.
  - On ack, compare i_wb_rdt with the held word. Set o_err on mismatch, then advance.
- Advance:
  - Address is incremented modulo 2^(aw-2); it wraps to 0 past the top.
  - Remaining count is decremented.
  - If the count reaches 0, go to DONE. Otherwise go to FILL.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- i_start is ignored while o_busy=1.
- o_err clears on an accepted i_start only.
- Reset mid-load aborts the transfer: state IDLE, stb low, byte lane index 0, partial word discarded.

## Timing
- Reset values:
  - o_ready=0, o_wb_stb=0, o_wb_we=0, o_busy=0, o_done=0, o_err=0.
  - o_wb_adr=0, o_wb_dat=0.
  - o_wb_sel=4'hF (constant).
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- o_ready rises the cycle after an accepted start. It drops the cycle after the fourth byte is accepted.
- o_wb_stb rises the cycle after the fourth byte is accepted.
- o_wb_stb deasserts in the cycle after i_wb_ack. The responder relies on this one-cycle stb drop after ack; the loader never re-strobes back-to-back.
- In READ, i_wb_rdt is sampled only in the i_wb_ack cycle.
- With the SRAM responder, i_wb_ack arrives 4 cycles after stb rises (stb is asserted in ack-4 through ack). Minimum per word without readback: 4 fill cycles + 5 write cycles.
- o_done is asserted the cycle after the last ack. For i_len=0, o_done is asserted the cycle after start.

## Configuration
- Macro: SUBSERVIENT_LOADER_READBACK_EN.
- Defined: the READ state and a 32-bit compare are present, and o_err behaves as specified.
- Undefined: WRITE goes directly to advance, o_err is tied to 0, and i_wb_rdt is unused.

## Structure
- Package subservient_loader_pkg holds:
  - the state enum (IDLE, FILL, WRITE, READ, DONE);
  - constant WB_SEL_ALL = 4'hF;
  - the lane-index width (2).
- Sub-module subservient_loader_pack: byte-to-word packer holding the lane counter and word register.
  - Outputs: word, word_valid.
  - Input: clear.
  - Resets on i_rst_n and clear.

## Test plan
- Load 2 words at base 0x10: stream 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> writes 0x44332211 @0x10, then 0x88776655 @0x11; exactly one o_done pulse.
- i_len=0 -> no stb ever; o_done one cycle after start; o_busy high for one cycle.
- Base = top word (2^(aw-2)-1), i_len=2 -> second write at address 0 (wrap).
- Stall stream (i_valid low 10 cycles between bytes) and delay ack by 7 cycles -> adr/dat/stb held stable; stb low the cycle after ack.
- Readback enabled, responder returns 0xDEADBEEF for a written 0x44332211 -> o_err=1 and stays set through done. The next accepted start clears it.
- Assert i_rst_n low during WRITE -> stb=0 immediately, no further ack handling; a new start after reset loads correctly from byte lane 0.
